// File: rtl/xadc_multich_meter.sv
// -----------------------------------------------------------------------------
// xadc_multich_meter
//
// Multi-channel XADC meter. It sits between the XADC wizard DRP port and the
// seven-segment digit driver.
//  * DRP side: when the XADC signals end-of-conversion on a monitored channel,
//    it issues a one-cycle DRP read, waits (bounded) for drdy_in and
//    accumulates the 12-bit code into that channel's accumulator.
//  * Every 2^AVG_LOG2 samples a channel's average register is rewritten.
//  * Every UPDATE_DIV clocks the selected channel's average (or peak) is scaled
//    to micro-units, clamped, and converted to BCD by a serial double-dabble.
//  * A 16-LED bar graph follows the selected channel's top nibble.
//
// Optional feature macro: XADC_PEAK_HOLD_EN (per-channel peak-hold registers,
// peak_mode / peak_clr inputs). Without it peak_mode and peak_clr are ignored.
//
// Ports:
//  CLK100MHZ     system clock
//  CPU_RESETN    asynchronous active-low reset
//  eoc_in        XADC end-of-conversion pulse
//  channel_in    XADC channel_out (7 bits)
//  drdy_in       DRP data ready
//  do_in         DRP read data, code in [15:4]
//  den_out       DRP enable pulse
//  daddr_out     DRP address
//  sel_ch        channel shown on digits / LEDs (>= NUM_CH selects channel 0)
//  peak_mode     show peak instead of current average
//  peak_clr      clear all peaks
//  digits_out    BCD digits, digit 0 in the LSBs
//  digits_valid  one-cycle pulse when digits_out updates
//  led           bar graph
//  busy          DRP read or BCD conversion in progress
// -----------------------------------------------------------------------------
module xadc_multich_meter #(
    parameter int         NUM_CH      = 4,
    parameter logic [6:0] CH_BASE     = 7'h10,
    parameter int         AVG_LOG2    = 2,
    parameter int         SCALE_MUL   = 250000,
    parameter int         SCALE_SHIFT = 10,
    parameter int         CLAMP_CODE  = 4093,
    parameter int         CLAMP_VAL   = 1000000,
    parameter int         BIN_W       = 20,
    parameter int         NUM_DIGITS  = 7,
    parameter int         UPDATE_DIV  = 20000000,
    parameter int         DRDY_TMO    = 31
) (
    input  logic                    CLK100MHZ,
    input  logic                    CPU_RESETN,
    input  logic                    eoc_in,
    input  logic [6:0]              channel_in,
    input  logic                    drdy_in,
    input  logic [15:0]             do_in,
    output logic                    den_out,
    output logic [6:0]              daddr_out,
    input  logic [3:0]              sel_ch,
    input  logic                    peak_mode,
    input  logic                    peak_clr,
    output logic [4*NUM_DIGITS-1:0] digits_out,
    output logic                    digits_valid,
    output logic [15:0]             led,
    output logic                    busy
);

    localparam int ACC_W  = 12 + AVG_LOG2;
    localparam int CNT_W  = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int CHI_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int TMO_W  = $clog2(DRDY_TMO + 1);
    localparam int REF_W  = $clog2(UPDATE_DIV + 1);
    localparam int BITS_W = $clog2(BIN_W + 1);
    localparam int DIG_W  = 4 * NUM_DIGITS;

    typedef enum logic [0:0] {DRP_IDLE = 1'b0, DRP_WAIT = 1'b1} drp_state_t;
    typedef enum logic [1:0] {CV_IDLE = 2'd0, CV_SHIFT = 2'd1, CV_DONE = 2'd2} cv_state_t;

    // Double-dabble correction: every BCD digit >= 5 gets +3 before the shift.
    function automatic logic [DIG_W-1:0] dabble_adj(input logic [DIG_W-1:0] b);
        logic [DIG_W-1:0] r;
        r = b;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = r[4*i +: 4] + 4'd3;
            end else begin
                r[4*i +: 4] = r[4*i +: 4];
            end
        end
        return r;
    endfunction

    // Bar graph: n = top nibble, n ones-plus-one lit, bottom LED always lit.
    function automatic logic [15:0] bar_of(input logic [11:0] v);
        logic [3:0]  n;
        logic [16:0] t;
        n = v[11:8];
        if (n == 4'd0) begin
            t = 17'h00001;
        end else begin
            t = (17'd2 << n) - 17'd1;
        end
        return t[15:0];
    endfunction

    // ---------------------------------------------------------------- DRP FSM
    drp_state_t       drp_state_q, drp_state_d;
    logic             den_q, den_d;
    logic [6:0]       daddr_q, daddr_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [CHI_W-1:0] ch_q, ch_d;
    logic             smp_we_s;
    logic [7:0]       ch_ext_s, base_ext_s;
    logic             in_range_s;
    logic [6:0]       ch_off_s;

    assign ch_ext_s   = {1'b0, channel_in};
    assign base_ext_s = {1'b0, CH_BASE};
    assign in_range_s = (ch_ext_s >= base_ext_s) && (ch_ext_s < (base_ext_s + 8'(NUM_CH)));
    assign ch_off_s   = channel_in - CH_BASE;

    // DRP next-state: launch a read on in-range EOC, then wait bounded for drdy.
    always_comb begin
        drp_state_d = drp_state_q;
        den_d       = 1'b0;
        daddr_d     = daddr_q;
        tmo_d       = tmo_q;
        ch_d        = ch_q;
        smp_we_s    = 1'b0;
        case (drp_state_q)
            DRP_IDLE: begin
                if (eoc_in && in_range_s) begin
                    den_d       = 1'b1;
                    daddr_d     = channel_in;
                    ch_d        = ch_off_s[CHI_W-1:0];
                    tmo_d       = {TMO_W{1'b0}};
                    drp_state_d = DRP_WAIT;
                end else begin
                    drp_state_d = DRP_IDLE;
                end
            end
            DRP_WAIT: begin
                // EOC seen here is intentionally dropped.
                if (drdy_in) begin
                    smp_we_s    = 1'b1;
                    drp_state_d = DRP_IDLE;
                end else if (tmo_q == TMO_W'(DRDY_TMO - 1)) begin
                    drp_state_d = DRP_IDLE;
                end else begin
                    tmo_d = tmo_q + {{(TMO_W-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                drp_state_d = DRP_IDLE;
            end
        endcase
    end

    // DRP state and output registers.
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            drp_state_q <= DRP_IDLE;
            den_q       <= 1'b0;
            daddr_q     <= 7'h00;
            tmo_q       <= {TMO_W{1'b0}};
            ch_q        <= {CHI_W{1'b0}};
        end else begin
            drp_state_q <= drp_state_d;
            den_q       <= den_d;
            daddr_q     <= daddr_d;
            tmo_q       <= tmo_d;
            ch_q        <= ch_d;
        end
    end

    // -------------------------------------------------------------- averaging
    logic [ACC_W-1:0] acc_q [NUM_CH];
    logic [CNT_W-1:0] cnt_q [NUM_CH];
    logic [11:0]      avg_q [NUM_CH];
    logic             avg_wr_q;
    logic [CHI_W-1:0] avg_wr_ch_q;
    logic [ACC_W-1:0] sum_s;
    logic             blk_done_s;
    logic [11:0]      avg_new_s;

    assign sum_s      = acc_q[ch_q] + ACC_W'(do_in[15:4]);
    assign blk_done_s = (cnt_q[ch_q] == CNT_W'((1 << AVG_LOG2) - 1));
    assign avg_new_s  = 12'(sum_s >> AVG_LOG2);

    // Accumulate accepted samples; the block-completing sample goes straight
    // into the average while the accumulator restarts from zero.
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            for (int k = 0; k < NUM_CH; k++) begin
                acc_q[k] <= {ACC_W{1'b0}};
                cnt_q[k] <= {CNT_W{1'b0}};
                avg_q[k] <= 12'h000;
            end
            avg_wr_q    <= 1'b0;
            avg_wr_ch_q <= {CHI_W{1'b0}};
        end else begin
            avg_wr_q <= 1'b0;
            if (smp_we_s) begin
                if (blk_done_s) begin
                    avg_q[ch_q] <= avg_new_s;
                    acc_q[ch_q] <= {ACC_W{1'b0}};
                    cnt_q[ch_q] <= {CNT_W{1'b0}};
                    avg_wr_q    <= 1'b1;
                    avg_wr_ch_q <= ch_q;
                end else begin
                    acc_q[ch_q] <= sum_s;
                    cnt_q[ch_q] <= cnt_q[ch_q] + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
        end
    end

    // ------------------------------------------------------- source selection
    logic [CHI_W-1:0] sel_idx_s;
    logic [11:0]      src_s;
    logic [63:0]      shifted_s;
    logic [BIN_W-1:0] scaled_s;
    logic             unused_s;

    assign sel_idx_s = ({1'b0, sel_ch} < 5'(NUM_CH)) ? sel_ch[CHI_W-1:0] : {CHI_W{1'b0}};

`ifdef XADC_PEAK_HOLD_EN
    logic [11:0] peak_q [NUM_CH];

    // Peak hold per channel; a clear coinciding with an average write keeps
    // the fresh average rather than zero.
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            for (int k = 0; k < NUM_CH; k++) begin
                peak_q[k] <= 12'h000;
            end
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (smp_we_s && blk_done_s && (ch_q == CHI_W'(k))) begin
                    if (peak_clr || (avg_new_s > peak_q[k])) begin
                        peak_q[k] <= avg_new_s;
                    end else begin
                        peak_q[k] <= peak_q[k];
                    end
                end else if (peak_clr) begin
                    peak_q[k] <= 12'h000;
                end else begin
                    peak_q[k] <= peak_q[k];
                end
            end
        end
    end

    assign src_s    = peak_mode ? peak_q[sel_idx_s] : avg_q[sel_idx_s];
    assign unused_s = ^{do_in[3:0], shifted_s[63:BIN_W]};
`else
    assign src_s    = avg_q[sel_idx_s];
    assign unused_s = ^{do_in[3:0], peak_mode, peak_clr, shifted_s[63:BIN_W]};
`endif

    assign shifted_s = (64'(src_s) * 64'(SCALE_MUL)) >> SCALE_SHIFT;
    assign scaled_s  = ({1'b0, src_s} >= 13'(CLAMP_CODE)) ? BIN_W'(CLAMP_VAL)
                                                          : shifted_s[BIN_W-1:0];

    // ----------------------------------------------------------------- LEDs
    logic [15:0] led_q;

    // Bar graph follows the selected channel, refreshed only when it gets a
    // new average (one cycle after the write, from the registered value).
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            led_q <= 16'h0001;
        end else if (avg_wr_q && (avg_wr_ch_q == sel_idx_s)) begin
            led_q <= bar_of(src_s);
        end else begin
            led_q <= led_q;
        end
    end

    // -------------------------------------------------------- refresh tick
    logic [REF_W-1:0] ref_q;
    logic             tick_s;

    assign tick_s = (ref_q == REF_W'(UPDATE_DIV - 1));

    // Free-running refresh divider.
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            ref_q <= {REF_W{1'b0}};
        end else if (tick_s) begin
            ref_q <= {REF_W{1'b0}};
        end else begin
            ref_q <= ref_q + {{(REF_W-1){1'b0}}, 1'b1};
        end
    end

    // ------------------------------------------------------- BCD conversion
    // Timeline: load on the tick edge, BIN_W shift edges, one publish edge, so
    // digits_valid is high BIN_W+2 cycles after the tick cycle.
    cv_state_t                 cv_state_q, cv_state_d;
    logic [BIN_W-1:0]          bin_q, bin_d;
    logic [DIG_W-1:0]          bcd_q, bcd_d;
    logic [BITS_W-1:0]         bits_q, bits_d;
    logic [DIG_W-1:0]          dig_q, dig_d;
    logic                      dval_q, dval_d;
    logic [DIG_W+BIN_W-1:0]    shl_s;

    // Conversion next-state; ticks arriving while converting are skipped.
    always_comb begin
        cv_state_d = cv_state_q;
        bin_d      = bin_q;
        bcd_d      = bcd_q;
        bits_d     = bits_q;
        dig_d      = dig_q;
        dval_d     = 1'b0;
        shl_s      = {dabble_adj(bcd_q), bin_q} << 1;
        case (cv_state_q)
            CV_IDLE: begin
                if (tick_s) begin
                    bin_d      = scaled_s;
                    bcd_d      = {DIG_W{1'b0}};
                    bits_d     = {BITS_W{1'b0}};
                    cv_state_d = CV_SHIFT;
                end else begin
                    cv_state_d = CV_IDLE;
                end
            end
            CV_SHIFT: begin
                {bcd_d, bin_d} = shl_s;
                if (bits_q == BITS_W'(BIN_W - 1)) begin
                    cv_state_d = CV_DONE;
                end else begin
                    bits_d = bits_q + {{(BITS_W-1){1'b0}}, 1'b1};
                end
            end
            CV_DONE: begin
                dig_d      = bcd_q;
                dval_d     = 1'b1;
                cv_state_d = CV_IDLE;
            end
            default: begin
                cv_state_d = CV_IDLE;
            end
        endcase
    end

    // Conversion registers and published digits.
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            cv_state_q <= CV_IDLE;
            bin_q      <= {BIN_W{1'b0}};
            bcd_q      <= {DIG_W{1'b0}};
            bits_q     <= {BITS_W{1'b0}};
            dig_q      <= {DIG_W{1'b0}};
            dval_q     <= 1'b0;
        end else begin
            cv_state_q <= cv_state_d;
            bin_q      <= bin_d;
            bcd_q      <= bcd_d;
            bits_q     <= bits_d;
            dig_q      <= dig_d;
            dval_q     <= dval_d;
        end
    end

    // --------------------------------------------------------------- busy
    logic busy_q;

    // Busy tracks the next state of both engines so it is glitch-free.
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            busy_q <= 1'b0;
        end else begin
            busy_q <= (drp_state_d != DRP_IDLE) || (cv_state_d != CV_IDLE);
        end
    end

    assign den_out      = den_q;
    assign daddr_out    = daddr_q;
    assign digits_out   = dig_q;
    assign digits_valid = dval_q;
    assign led          = led_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_xadc_multich_meter.sv
// Directed bench for xadc_multich_meter with a short refresh period.
module tb_xadc_multich_meter;

    localparam int UD = 64;

    logic        clk = 1'b0;
    logic        CPU_RESETN = 1'b0;
    logic        eoc_in = 1'b0;
    logic [6:0]  channel_in = 7'h00;
    logic        drdy_in = 1'b0;
    logic [15:0] do_in = 16'h0000;
    logic [3:0]  sel_ch = 4'd0;
    logic        peak_mode = 1'b0;
    logic        peak_clr = 1'b0;
    logic        den_out;
    logic [6:0]  daddr_out;
    logic [27:0] digits_out;
    logic        digits_valid;
    logic [15:0] led;
    logic        busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    xadc_multich_meter #(.UPDATE_DIV(UD)) dut (
        .CLK100MHZ(clk), .CPU_RESETN(CPU_RESETN), .eoc_in(eoc_in),
        .channel_in(channel_in), .drdy_in(drdy_in), .do_in(do_in),
        .den_out(den_out), .daddr_out(daddr_out), .sel_ch(sel_ch),
        .peak_mode(peak_mode), .peak_clr(peak_clr), .digits_out(digits_out),
        .digits_valid(digits_valid), .led(led), .busy(busy)
    );

    task automatic do_reset;
        @(negedge clk);
        CPU_RESETN = 1'b0;
        eoc_in = 1'b0; channel_in = 7'h00; drdy_in = 1'b0; do_in = 16'h0000;
        sel_ch = 4'd0; peak_mode = 1'b0; peak_clr = 1'b0;
        repeat (3) @(negedge clk);
        CPU_RESETN = 1'b1;
    endtask

    task automatic drp_sample(input logic [6:0] addr, input logic [15:0] data);
        @(negedge clk);
        eoc_in = 1'b1; channel_in = addr;
        @(negedge clk);
        eoc_in = 1'b0; drdy_in = 1'b1; do_in = data;
        @(negedge clk);
        drdy_in = 1'b0;
    endtask

    task automatic feed(input logic [6:0] addr, input logic [15:0] data, input int n);
        for (int i = 0; i < n; i++) drp_sample(addr, data);
        repeat (3) @(negedge clk);
    endtask

    // Second valid pulse is guaranteed to come from a tick after the caller's writes.
    task automatic wait_digits(output bit ok);
        int seen;
        seen = 0;
        ok = 1'b0;
        for (int i = 0; i < 3 * UD + 50; i++) begin
            @(negedge clk);
            if (digits_valid) begin
                seen++;
                if (seen == 2) begin
                    ok = 1'b1;
                    break;
                end
            end
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        CPU_RESETN = 1'b0;
        #1;
        checks++;
        if ({den_out, daddr_out, digits_out, digits_valid, led, busy} !==
            {1'b0, 7'h00, 28'h0000000, 1'b0, 16'h0001, 1'b0}) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected %h",
                     {den_out, daddr_out, digits_out, digits_valid, led, busy},
                     {1'b0, 7'h00, 28'h0000000, 1'b0, 16'h0001, 1'b0});
        end
        do_reset;
    endtask

    task automatic test_latency;
        int found;
        do_reset;
        found = -1;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if (digits_valid) begin
                found = i;
                break;
            end
        end
        checks++;
        if (found !== UD + 21) begin
            errors++;
            $display("FAIL first_valid_cycle: got %0d expected %0d", found, UD + 21);
        end
        checks++;
        if (digits_out !== 28'h0000000) begin
            errors++;
            $display("FAIL zero_digits: got %h expected %h", digits_out, 28'h0000000);
        end
        @(negedge clk);
        checks++;
        if (digits_valid !== 1'b0) begin
            errors++;
            $display("FAIL valid_one_cycle: got %b expected 0", digits_valid);
        end
    endtask

    task automatic test_handshake;
        do_reset;
        @(negedge clk);
        eoc_in = 1'b1; channel_in = 7'h11;
        @(negedge clk);
        checks++;
        if ({den_out, daddr_out, busy} !== {1'b1, 7'h11, 1'b1}) begin
            errors++;
            $display("FAIL den_addr: got %h expected %h", {den_out, daddr_out, busy}, {1'b1, 7'h11, 1'b1});
        end
        eoc_in = 1'b0; drdy_in = 1'b1; do_in = 16'h8000;
        @(negedge clk);
        drdy_in = 1'b0;
        checks++;
        if (den_out !== 1'b0) begin
            errors++;
            $display("FAIL den_width: got %b expected 0", den_out);
        end
    endtask

    task automatic test_average;
        bit ok;
        do_reset;
        feed(7'h10, 16'h8000, 3);
        checks++;
        if (led !== 16'h0001) begin
            errors++;
            $display("FAIL led_partial_block: got %h expected %h", led, 16'h0001);
        end
        feed(7'h10, 16'h8000, 1);
        checks++;
        if (led !== 16'h01FF) begin
            errors++;
            $display("FAIL led_avg800: got %h expected %h", led, 16'h01FF);
        end
        wait_digits(ok);
        checks++;
        if (!ok || digits_out !== 28'h0500000) begin
            errors++;
            $display("FAIL digits_avg800: got %h ok=%b expected %h", digits_out, ok, 28'h0500000);
        end
        do_reset;
        drp_sample(7'h10, 16'h4000);
        drp_sample(7'h10, 16'h4000);
        drp_sample(7'h10, 16'hC000);
        drp_sample(7'h10, 16'hC000);
        wait_digits(ok);
        checks++;
        if (!ok || digits_out !== 28'h0500000) begin
            errors++;
            $display("FAIL digits_mixed: got %h ok=%b expected %h", digits_out, ok, 28'h0500000);
        end
    endtask

    task automatic test_clamp;
        bit ok;
        logic [15:0] codes [5];
        logic [27:0] exp_d [5];
        logic [15:0] exp_l [5];
        codes[0] = 16'hFFF0; exp_d[0] = 28'h1000000; exp_l[0] = 16'hFFFF;
        codes[1] = 16'hFFD0; exp_d[1] = 28'h1000000; exp_l[1] = 16'hFFFF;
        codes[2] = 16'hFFC0; exp_d[2] = 28'h0999023; exp_l[2] = 16'hFFFF;
        codes[3] = 16'h4000; exp_d[3] = 28'h0250000; exp_l[3] = 16'h001F;
        codes[4] = 16'h0000; exp_d[4] = 28'h0000000; exp_l[4] = 16'h0001;
        do_reset;
        for (int i = 0; i < 5; i++) begin
            feed(7'h10, codes[i], 4);
            checks++;
            if (led !== exp_l[i]) begin
                errors++;
                $display("FAIL clamp_led[%0d]: got %h expected %h", i, led, exp_l[i]);
            end
            wait_digits(ok);
            checks++;
            if (!ok || digits_out !== exp_d[i]) begin
                errors++;
                $display("FAIL clamp_digits[%0d]: got %h ok=%b expected %h", i, digits_out, ok, exp_d[i]);
            end
        end
    endtask

    task automatic test_range;
        logic [6:0] bad [3];
        bad[0] = 7'h03; bad[1] = 7'h14; bad[2] = 7'h0F;
        do_reset;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            eoc_in = 1'b1; channel_in = bad[i];
            @(negedge clk);
            eoc_in = 1'b0;
            checks++;
            if (den_out !== 1'b0) begin
                errors++;
                $display("FAIL out_of_range[%h]: got den %b expected 0", bad[i], den_out);
            end
        end
        @(negedge clk);
        eoc_in = 1'b1; channel_in = 7'h13;
        @(negedge clk);
        eoc_in = 1'b0;
        checks++;
        if ({den_out, daddr_out} !== {1'b1, 7'h13}) begin
            errors++;
            $display("FAIL last_channel: got %h expected %h", {den_out, daddr_out}, {1'b1, 7'h13});
        end
        drdy_in = 1'b1; do_in = 16'h0000;
        @(negedge clk);
        drdy_in = 1'b0;
    endtask

    task automatic test_timeout;
        do_reset;
        @(negedge clk);
        eoc_in = 1'b1; channel_in = 7'h10;
        @(negedge clk);
        eoc_in = 1'b0;
        for (int j = 1; j <= 30; j++) begin
            @(negedge clk);
            if (j == 10) begin
                eoc_in = 1'b1;
            end else if (j == 11) begin
                checks++;
                if (den_out !== 1'b0) begin
                    errors++;
                    $display("FAIL eoc_in_wait: got den %b expected 0", den_out);
                end
                eoc_in = 1'b0;
            end else if (j == 30) begin
                eoc_in = 1'b1;
            end
        end
        @(negedge clk);
        checks++;
        if (den_out !== 1'b0) begin
            errors++;
            $display("FAIL timeout_edge: got den %b expected 0", den_out);
        end
        @(negedge clk);
        checks++;
        if ({den_out, daddr_out} !== {1'b1, 7'h10}) begin
            errors++;
            $display("FAIL after_timeout: got %h expected %h", {den_out, daddr_out}, {1'b1, 7'h10});
        end
        eoc_in = 1'b0; drdy_in = 1'b1; do_in = 16'h0000;
        @(negedge clk);
        drdy_in = 1'b0;
    endtask

    task automatic test_sel_range;
        bit ok;
        do_reset;
        sel_ch = 4'd9;
        feed(7'h10, 16'h8000, 4);
        feed(7'h11, 16'h4000, 4);
        checks++;
        if (led !== 16'h01FF) begin
            errors++;
            $display("FAIL sel9_led: got %h expected %h", led, 16'h01FF);
        end
        wait_digits(ok);
        checks++;
        if (!ok || digits_out !== 28'h0500000) begin
            errors++;
            $display("FAIL sel9_digits: got %h ok=%b expected %h", digits_out, ok, 28'h0500000);
        end
        sel_ch = 4'd1;
        wait_digits(ok);
        checks++;
        if (!ok || digits_out !== 28'h0250000) begin
            errors++;
            $display("FAIL sel1_digits: got %h ok=%b expected %h", digits_out, ok, 28'h0250000);
        end
    endtask

    task automatic test_reset_mid;
        bit ok;
        bit seen;
        do_reset;
        feed(7'h10, 16'h8000, 4);
        wait_digits(ok);
        checks++;
        if (!ok || digits_out !== 28'h0500000) begin
            errors++;
            $display("FAIL pre_reset_digits: got %h ok=%b expected %h", digits_out, ok, 28'h0500000);
        end
        repeat (UD - 17) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_converting: got %b expected 1", busy);
        end
        CPU_RESETN = 1'b0;
        #1;
        checks++;
        if ({den_out, daddr_out, digits_out, digits_valid, led, busy} !==
            {1'b0, 7'h00, 28'h0000000, 1'b0, 16'h0001, 1'b0}) begin
            errors++;
            $display("FAIL reset_mid_conv: got %h expected %h",
                     {den_out, daddr_out, digits_out, digits_valid, led, busy},
                     {1'b0, 7'h00, 28'h0000000, 1'b0, 16'h0001, 1'b0});
        end
        repeat (2) @(negedge clk);
        CPU_RESETN = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < UD + 15; i++) begin
            @(negedge clk);
            if (digits_valid) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL aborted_conv_valid: got %b expected 0", seen);
        end
    endtask

`ifdef XADC_PEAK_HOLD_EN
    task automatic test_peak;
        bit ok;
        do_reset;
        feed(7'h10, 16'h8000, 4);
        feed(7'h10, 16'h4000, 4);
        peak_mode = 1'b1;
        wait_digits(ok);
        checks++;
        if (!ok || digits_out !== 28'h0500000) begin
            errors++;
            $display("FAIL peak_digits: got %h ok=%b expected %h", digits_out, ok, 28'h0500000);
        end
        peak_mode = 1'b0;
        wait_digits(ok);
        checks++;
        if (!ok || digits_out !== 28'h0250000) begin
            errors++;
            $display("FAIL current_digits: got %h ok=%b expected %h", digits_out, ok, 28'h0250000);
        end
        @(negedge clk);
        peak_clr = 1'b1;
        @(negedge clk);
        peak_clr = 1'b0;
        peak_mode = 1'b1;
        wait_digits(ok);
        checks++;
        if (!ok || digits_out !== 28'h0000000) begin
            errors++;
            $display("FAIL cleared_peak: got %h ok=%b expected %h", digits_out, ok, 28'h0000000);
        end
        feed(7'h10, 16'h4000, 4);
        wait_digits(ok);
        checks++;
        if (!ok || digits_out !== 28'h0250000) begin
            errors++;
            $display("FAIL peak_after_clear: got %h ok=%b expected %h", digits_out, ok, 28'h0250000);
        end
    endtask
`endif

    initial begin
        test_reset;
        test_latency;
        test_handshake;
        test_average;
        test_clamp;
        test_range;
        test_timeout;
        test_sel_range;
        test_reset_mid;
`ifdef XADC_PEAK_HOLD_EN
        test_peak;
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/xadc_multich_meter.md
Name: xadc_multich_meter

Overview:
- Parametrised multi-channel successor to the single-channel XADC voltmeter logic.
- Sits between the XADC wizard DRP port and the DigitToSeg display driver.
- Per channel: handshakes DRP reads, averages 2^AVG_LOG2 samples, keeps one average register.
- For the selected channel: scales to micro-units, converts to BCD with a sequential double-dabble, and drives a 16-LED bar graph.

Parameters:
- NUM_CH, 4: number of channels monitored (1..16).
- CH_BASE, 7'h10: XADC channel address of channel 0 (VAUX0); channel k = CH_BASE+k.
- AVG_LOG2, 2: log2 of the samples averaged per channel (0..6).
- SCALE_MUL, 250000: scale multiplier applied to the 12-bit code.
- SCALE_SHIFT, 10: right shift after the multiply.
- CLAMP_CODE, 4093: averaged codes at or above this display CLAMP_VAL.
- CLAMP_VAL, 1000000: displayed value when clamped.
- BIN_W, 20: width of the scaled binary value fed to BCD.
- NUM_DIGITS, 7: BCD digits produced.
- UPDATE_DIV, 20000000: display refresh period in clocks.
- DRDY_TMO, 31: maximum cycles to wait for drdy_in.

Ports:
- CLK100MHZ  in  1: system clock.
- CPU_RESETN  in  1: asynchronous active-low reset.
- eoc_in  in  1: XADC end-of-conversion pulse.
- channel_in  in  7: XADC channel_out.
- drdy_in  in  1: DRP data ready.
- do_in  in  16: DRP read data.
- den_out  out  1: DRP enable pulse.
- daddr_out  out  7: DRP address.
- sel_ch  in  4: channel shown on display/LEDs.
- peak_mode  in  1: show peak instead of current (optional feature).
- peak_clr  in  1: clear peaks (optional feature).
- digits_out  out  4*NUM_DIGITS: BCD digits, digit 0 in LSBs.
- digits_valid  out  1: one-cycle pulse when digits_out updates.
- led  out  16: bar graph.
- busy  out  1: high while a DRP read or BCD conversion is in progress.

Behaviour:
- Reset values: den_out=0, daddr_out=0, digits_out=0, digits_valid=0, led=16'h0001, busy=0. All accumulators, sample counters, averages, peaks and the refresh counter clear to 0. Reset mid-read or mid-conversion aborts it; nothing is presented.
- DRP FSM states:
  - IDLE: eoc_in=1 and CH_BASE <= channel_in < CH_BASE+NUM_CH -> next cycle den_out=1 for exactly 1 cycle, daddr_out=channel_in, go to WAIT. Out-of-range channels are ignored.
  - WAIT: drdy_in=1 -> code=do_in[15:4] is added to acc[ch], cnt[ch]++, go to IDLE. No drdy within DRDY_TMO cycles -> sample discarded, go to IDLE. eoc_in in WAIT is dropped.
- Averaging:
  - acc width 12+AVG_LOG2.
  - When cnt[ch] wraps to 0 (after 2^AVG_LOG2 samples): avg[ch] <= acc >> AVG_LOG2, acc cleared in the same cycle.
  - The sample completing the block is included in the average.
- Refresh tick every UPDATE_DIV cycles. Source is avg[sel_ch]; sel_ch >= NUM_CH selects channel 0.
  - If the source >= CLAMP_CODE, bin = CLAMP_VAL.
  - Otherwise bin = (src*SCALE_MUL) >> SCALE_SHIFT, truncated to BIN_W bits.
- BCD conversion:
  - Double-dabble, one bit per cycle.
  - digits_out and digits_valid update exactly BIN_W+2 cycles after the tick.
  - A tick arriving while conversion is busy is skipped.
- LED bar: updates on every avg write for sel_ch. With n = avg[11:8], led = (2<<n)-1 for n>=1 and 16'h0001 for n=0.

Optional Feature:
- Macro XADC_PEAK_HOLD_EN.
- Defined:
  - Each channel keeps peak[ch] = max of its averages.
  - peak_mode=1 uses peak[sel_ch] as the source for both display and LEDs.
  - peak_clr=1 sets every peak to 0. If it coincides with an avg write, peak takes the new avg.
- Undefined: no peak registers; peak_mode and peak_clr are ignored; behaviour equals peak_mode=0.

Test Plan:
- DRP handshake: eoc_in with channel_in=7'h11 -> den_out high 1 cycle, daddr_out=7'h11. drdy_in with do_in=16'h8000 -> sample accepted.
- Averaging and scaling: 4 samples of do_in=16'h8000 on channel 0, sel_ch=0.
  - led=16'h01FF.
  - On the next tick, digits_valid after BIN_W+2=22 cycles with digits 0,5,0,0,0,0,0 (500000).
  - Samples 0x4000,0x4000,0xC000,0xC000 -> avg 0x800 -> same 500000.
- Clamp and scaling: avg code 4095 -> digits 1000000. Avg code 0x400 -> 0250000. Avg 0 -> all zero, led=16'h0001.
- Boundaries:
  - channel_in=7'h03 -> no den_out.
  - No drdy_in -> return to IDLE after 31 cycles and the next eoc is serviced.
  - eoc during WAIT -> dropped.
  - sel_ch=9 with NUM_CH=4 -> channel 0 displayed.
- Reset mid-conversion: deassert CPU_RESETN 5 cycles after a tick -> outputs at their reset values immediately, no digits_valid.
- XADC_PEAK_HOLD_EN:
  - Averages 0x800 then 0x400, peak_mode=1 -> display 500000. peak_mode=0 -> 250000.
  - peak_clr then peak_mode=1 -> 0 until the next avg write.
